// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings and defaults for the floor slot scheduler
package game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } game_state_e;

  localparam int NUM_SLOTS         = 8;
  localparam int SLOT_W            = 3;
  localparam int GAP_INIT_DEF      = 120;
  localparam int GAP_MIN_DEF       = 40;
  localparam int GAP_STEP_DEF      = 4;
  localparam int SPEEDUP_EVERY_DEF = 16;
endpackage

// File: rtl/free_slot_finder.sv
// rtl/free_slot_finder.sv - rotating priority encoder over the free-slot mask
module free_slot_finder
  import game_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] free,
  input  logic [SLOT_W-1:0]    start_ptr,
  output logic                 found,
  output logic [SLOT_W-1:0]    idx
);
  logic [SLOT_W-1:0] cand;

  // Scan from the farthest offset down so the nearest free slot is the last one kept.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      cand = start_ptr + SLOT_W'(i);
      if (free[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/floor_slot_scheduler.sv
// rtl/floor_slot_scheduler.sv - game FSM, spawn timer and round-robin slot allocator
module floor_slot_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS_P   = NUM_SLOTS,
  parameter int GAP_INIT      = GAP_INIT_DEF,
  parameter int GAP_MIN       = GAP_MIN_DEF,
  parameter int GAP_STEP      = GAP_STEP_DEF,
  parameter int SPEEDUP_EVERY = SPEEDUP_EVERY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 die,
  input  logic [NUM_SLOTS-1:0] slot_done,
  input  logic                 spawn_ack,
  output logic                 spawn_valid,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic [NUM_SLOTS-1:0] enable,
  output logic [8:0]           time_gap,
  output logic [15:0]          score,
  output logic [1:0]           game_state
);
  game_state_e       state, state_nxt;
  logic              new_game, die_now;
  logic [8:0]        gap_cnt;
  logic              pending;
  logic [SLOT_W-1:0] rr_ptr;
  logic [15:0]       spd_cnt;
  logic              found;
  logic [SLOT_W-1:0] free_idx;
  logic              play_run, expire, issue, acked, speedup;
  logic [NUM_SLOTS-1:0] ack_mask;
  logic [8:0]        gap_dec;

  free_slot_finder u_finder (
    .free      (~enable),
    .start_ptr (rr_ptr),
    .found     (found),
    .idx       (free_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    new_game  = 1'b0;
    die_now   = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: if (start) begin
        state_nxt = ST_PLAY;
        new_game  = 1'b1;
      end
      ST_PLAY: if (die) begin
        state_nxt = ST_OVER;
        die_now   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // gap_cnt may sit above a freshly shrunk time_gap, so expiry is a >= compare.
  assign play_run = (state == ST_PLAY) && !die;
  assign expire   = play_run && tick && (gap_cnt >= time_gap - 9'd1);
  assign issue    = play_run && pending && !spawn_valid && found;
  assign acked    = play_run && spawn_valid && spawn_ack;
  assign ack_mask = acked ? (NUM_SLOTS'(1) << spawn_slot) : '0;
  assign speedup  = acked && (spd_cnt == 16'(SPEEDUP_EVERY - 1));
  assign gap_dec  = (time_gap >= 9'(GAP_MIN + GAP_STEP)) ? time_gap - 9'(GAP_STEP)
                                                         : 9'(GAP_MIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable      <= '0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      time_gap    <= 9'(GAP_INIT);
      score       <= '0;
      gap_cnt     <= '0;
      pending     <= 1'b0;
      rr_ptr      <= '0;
      spd_cnt     <= '0;
    end else if (new_game) begin
      enable      <= '0;
      spawn_valid <= 1'b0;
      time_gap    <= 9'(GAP_INIT);
      score       <= '0;
      gap_cnt     <= '0;
      pending     <= 1'b1;
      rr_ptr      <= '0;
      spd_cnt     <= '0;
    end else if (die_now) begin
      spawn_valid <= 1'b0;
      pending     <= 1'b0;
    end else if (play_run) begin
      if (tick) gap_cnt <= expire ? 9'd0 : gap_cnt + 9'd1;
      enable <= (enable & ~slot_done) | ack_mask;
      if (issue) begin
        spawn_valid <= 1'b1;
        spawn_slot  <= free_idx;
        pending     <= 1'b0;
      end else if (expire) begin
        pending <= 1'b1;
      end
      if (acked) begin
        spawn_valid <= 1'b0;
        rr_ptr      <= spawn_slot + SLOT_W'(1);
        if (score != 16'hFFFF) score <= score + 16'd1;
        if (speedup) begin
          spd_cnt  <= '0;
          time_gap <= gap_dec;
        end else begin
          spd_cnt <= spd_cnt + 16'd1;
        end
      end
    end
  end

  assign game_state = state;
endmodule

// File: tb/tb_floor_slot_scheduler.sv
// tb/tb_floor_slot_scheduler.sv - randomized and directed bench against a slot-level game model
module tb_floor_slot_scheduler;
  localparam int GI = 4, GM = 2, GS = 1, SE = 2;

  logic       clk = 1'b0, rst = 1'b0;
  logic       tick = 1'b0, start = 1'b0, die = 1'b0, spawn_ack = 1'b0;
  logic [7:0] slot_done = 8'h00;
  logic       spawn_valid;
  logic [2:0] spawn_slot;
  logic [7:0] enable;
  logic [8:0] time_gap;
  logic [15:0] score;
  logic [1:0] game_state;

  always #5 clk = ~clk;

  floor_slot_scheduler #(
    .GAP_INIT(GI), .GAP_MIN(GM), .GAP_STEP(GS), .SPEEDUP_EVERY(SE)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .die(die),
    .slot_done(slot_done), .spawn_ack(spawn_ack), .spawn_valid(spawn_valid),
    .spawn_slot(spawn_slot), .enable(enable), .time_gap(time_gap),
    .score(score), .game_state(game_state)
  );

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game model: slots as a bit array, counters as plain integers.
  int m_state, m_slot, m_gap, m_cnt, m_rr, m_spd, m_score;
  bit m_en[8];
  bit m_valid, m_pend;

  function automatic logic [7:0] m_mask();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_en[k];
    return v;
  endfunction

  function automatic int m_first_free();
    for (int k = 0; k < 8; k++)
      if (!m_en[(m_rr + k) % 8]) return (m_rr + k) % 8;
    return -1;
  endfunction

  task automatic m_reset();
    m_state = 0; m_valid = 0; m_slot = 0; m_gap = GI; m_score = 0;
    m_cnt = 0; m_pend = 0; m_rr = 0; m_spd = 0;
    for (int k = 0; k < 8; k++) m_en[k] = 0;
  endtask

  task automatic m_step(input bit tk, input bit st, input bit di, input logic [7:0] dn, input bit ak);
    int tgt;
    bit exp_t, issue;
    if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_valid = 0; m_gap = GI; m_score = 0;
        m_cnt = 0; m_pend = 1; m_rr = 0; m_spd = 0;
        for (int k = 0; k < 8; k++) m_en[k] = 0;
      end
    end else if (di) begin
      m_state = 2; m_valid = 0; m_pend = 0;
    end else begin
      tgt   = m_first_free();
      issue = m_pend && !m_valid && (tgt >= 0);
      exp_t = tk && (m_cnt >= m_gap - 1);
      if (tk) m_cnt = exp_t ? 0 : m_cnt + 1;
      for (int k = 0; k < 8; k++) if (dn[k]) m_en[k] = 0;
      if (m_valid && ak) begin
        m_en[m_slot] = 1;
        m_valid = 0;
        m_rr = (m_slot + 1) % 8;
        if (m_score < 65535) m_score++;
        m_spd++;
        if (m_spd == SE) begin
          m_spd = 0;
          m_gap = (m_gap - GS < GM) ? GM : m_gap - GS;
        end
      end
      if (issue) begin
        m_valid = 1; m_slot = tgt; m_pend = 0;
      end else if (exp_t) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("game_state", 32'(game_state), 32'(m_state));
    chk("enable", 32'(enable), 32'(m_mask()));
    chk("spawn_valid", 32'(spawn_valid), 32'(m_valid));
    chk("spawn_slot", 32'(spawn_slot), 32'(m_slot));
    chk("time_gap", 32'(time_gap), 32'(m_gap));
    chk("score", 32'(score), 32'(m_score));
  endtask

  task automatic step(input bit tk, input bit st, input bit di, input logic [7:0] dn, input bit ak);
    tick = tk; start = st; die = di; slot_done = dn; spawn_ack = ak;
    @(posedge clk);
    m_step(tk, st, di, dn, ak);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!m_valid && b < 50) begin
      step(1, 0, 0, 8'h00, 0);
      b++;
    end
    if (!m_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check_all();
    chk("rst_state", 32'(game_state), 0);
    chk("rst_gap", 32'(time_gap), GI);
    rst = 1'b1;

    step(0, 1, 0, 8'h00, 0);
    chk("start_state", 32'(game_state), 1);
    step(0, 0, 0, 8'h00, 0);
    chk("first_valid", 32'(spawn_valid), 1);
    chk("first_slot", 32'(spawn_slot), 0);
    step(0, 0, 0, 8'h00, 1);
    chk("first_enable", 32'(enable), 8'h01);
    chk("first_score", 32'(score), 1);

    wait_valid();
    chk("rr_slot1", 32'(spawn_slot), 1);
    step(1, 0, 0, 8'h00, 1);
    chk("second_enable", 32'(enable), 8'h03);
    chk("second_gap", 32'(time_gap), 3);
    for (int n = 0; n < 6; n++) begin
      wait_valid();
      step(1, 0, 0, 8'h00, 1);
    end
    chk("full_enable", 32'(enable), 8'hFF);
    chk("gap_floor", 32'(time_gap), GM);
    for (int n = 0; n < 12; n++) begin
      step(1, 0, 0, 8'h00, 0);
      chk("full_no_valid", 32'(spawn_valid), 0);
    end
    step(0, 0, 0, 8'h20, 0);
    chk("done5_enable", 32'(enable), 8'hDF);
    step(0, 0, 0, 8'h00, 0);
    chk("done5_valid", 32'(spawn_valid), 1);
    chk("done5_slot", 32'(spawn_slot), 5);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h3E, 0);
    chk("wrap_enable", 32'(enable), 8'hC1);
    wait_valid();
    chk("wrap_slot", 32'(spawn_slot), 1);

    for (int n = 0; n < 10; n++) begin
      step(1, 0, 0, 8'h00, 0);
      chk("hold_valid", 32'(spawn_valid), 1);
      chk("hold_slot", 32'(spawn_slot), 1);
    end
    step(0, 0, 1, 8'h00, 1);
    chk("die_valid", 32'(spawn_valid), 0);
    chk("die_state", 32'(game_state), 2);
    chk("die_enable", 32'(enable), 8'hC1);
    for (int n = 0; n < 5; n++) step(1, 0, 0, 8'hFF, 1);
    chk("over_enable", 32'(enable), 8'hC1);
    step(0, 1, 0, 8'h00, 0);
    chk("restart_state", 32'(game_state), 1);
    chk("restart_enable", 32'(enable), 8'h00);
    chk("restart_score", 32'(score), 0);

    wait_valid();
    step(1, 0, 0, 8'h00, 1);
    wait_valid();
    step(1, 0, 0, 8'h00, 1);
    wait_valid();
    chk("sim_slot2", 32'(spawn_slot), 2);
    step(1, 0, 0, 8'h04, 1);
    chk("ack_wins", 32'(enable), 8'h07);
    wait_valid();
    chk("sim_slot3", 32'(spawn_slot), 3);
    step(1, 0, 0, 8'h01, 1);
    chk("ack_and_done", 32'(enable), 8'h0E);

    wait_valid();
    #2 rst = 1'b0;
    #1 m_reset();
    check_all();
    chk("async_rst_valid", 32'(spawn_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
           8'($urandom & $urandom & $urandom), $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
